// File: rtl/pixel_threshold_proc_pkg.sv
// Shared definitions for the pixel threshold / greyscale processor stage.
package pixel_threshold_proc_pkg;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_TH   = 2'b01;
  localparam logic [1:0] MODE_GRAY = 2'b10;

  localparam int COEF_R_DEF = 77;
  localparam int COEF_G_DEF = 150;
  localparam int COEF_B_DEF = 29;

  localparam int STG_BYTES = 12;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } proc_state_e;

  // BMP row length in bytes: 3 bytes per pixel rounded up to a 4-byte multiple.
  function automatic logic [17:0] row_bytes_of(input logic [15:0] width);
    logic [17:0] px;
    px = 18'(width) * 18'd3;
    return (px + 18'd3) & ~18'd3;
  endfunction

endpackage

// File: rtl/pixel_threshold_proc_grey.sv
// Combinational BGR -> grey conversion with optional black/white threshold.
module pixel_grey_calc
  import pixel_threshold_proc_pkg::*;
#(
  parameter int COEF_R = COEF_R_DEF,
  parameter int COEF_G = COEF_G_DEF,
  parameter int COEF_B = COEF_B_DEF
) (
  input  logic [7:0] b,
  input  logic [7:0] g,
  input  logic [7:0] r,
  input  logic [1:0] mode,
  input  logic [7:0] thr,
  output logic [7:0] pix_out
);

  logic [15:0] sum;
  logic [7:0]  grey;

  always_comb begin
    sum  = 16'(COEF_R) * 16'(r) + 16'(COEF_G) * 16'(g) + 16'(COEF_B) * 16'(b);
    grey = sum[15:8];
    if (mode == MODE_TH) pix_out = (grey >= thr) ? '1 : '0;
    else                 pix_out = grey;
  end

endmodule

// File: rtl/pixel_threshold_proc.sv
// Pixel processor: BMP pixel-array words in, thresholded/grey words out, byte count preserved.
module pixel_threshold_proc
  import pixel_threshold_proc_pkg::*;
#(
  parameter int DATA_BUS_SIZE = 32,
  parameter int COEF_R        = COEF_R_DEF,
  parameter int COEF_G        = COEF_G_DEF,
  parameter int COEF_B        = COEF_B_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode,
  input  logic [7:0]               data_proc,
  input  logic [15:0]              width_px,
  input  logic [DATA_BUS_SIZE-1:0] data_in,
  input  logic                     data_in_vld,
  input  logic                     eof,
  output logic [DATA_BUS_SIZE-1:0] data_out,
  output logic                     vld_out,
  output logic                     proc_done,
  output logic                     err
);

  proc_state_e  state_q, state_d;
  logic [1:0]   mode_q;
  logic [7:0]   thr_q;
  logic [15:0]  width_q;
  logic [17:0]  col_q, col_d;
  logic [15:0]  pend_q, pend_d;
  logic [1:0]   pend_cnt_q, pend_cnt_d;
  logic [95:0]  stg_q, stg_d;
  logic [3:0]   stg_cnt_q, stg_cnt_d;

  logic [1:0]   cur_mode;
  logic [7:0]   cur_thr;
  logic [15:0]  cur_width;
  logic [17:0]  px_bytes, row_bytes;
  logic [7:0]   lane [4];
  logic [7:0]   strm [6];
  logic [2:0]   n_pix, strm_cnt;
  logic [1:0]   npx, lo;
  logic [7:0]   px_out [2];
  logic         accept, mode_ok;
  logic [47:0]  new_b;
  logic [2:0]   new_k;
  logic [143:0] cmb, rem;
  logic [4:0]   cmb_cnt, rem_cnt;
  logic         emit, ovf, err_set;

  // The accepting IDLE cycle uses the live inputs; later words use the latched copies.
  always_comb begin
    cur_mode  = (state_q == S_IDLE) ? mode      : mode_q;
    cur_thr   = (state_q == S_IDLE) ? data_proc : thr_q;
    cur_width = (state_q == S_IDLE) ? width_px  : width_q;
    px_bytes  = 18'(cur_width) * 18'd3;
    row_bytes = row_bytes_of(cur_width);
    n_pix     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      lane[i] = data_in[8*i +: 8];
      if (col_q + 18'(i) < px_bytes) n_pix = n_pix + 3'd1;
    end
    strm_cnt = 3'(pend_cnt_q) + n_pix;
    // Carried bytes first, then this word's pixel lanes; padding is always a word tail.
    for (int unsigned j = 0; j < 6; j++) begin
      strm[j] = '0;
      if (j < 32'(pend_cnt_q))
        strm[j] = (j == 0) ? pend_q[7:0] : pend_q[15:8];
      else if (j - 32'(pend_cnt_q) < 32'(n_pix))
        strm[j] = lane[2'(j - 32'(pend_cnt_q))];
    end
    if (strm_cnt >= 3'd6) begin
      npx = 2'd2;
      lo  = 2'(strm_cnt - 3'd6);
    end else if (strm_cnt >= 3'd3) begin
      npx = 2'd1;
      lo  = 2'(strm_cnt - 3'd3);
    end else begin
      npx = 2'd0;
      lo  = 2'(strm_cnt);
    end
  end

  pixel_grey_calc #(.COEF_R(COEF_R), .COEF_G(COEF_G), .COEF_B(COEF_B)) u_grey0 (
    .b(strm[0]), .g(strm[1]), .r(strm[2]), .mode(cur_mode), .thr(cur_thr), .pix_out(px_out[0])
  );

  pixel_grey_calc #(.COEF_R(COEF_R), .COEF_G(COEF_G), .COEF_B(COEF_B)) u_grey1 (
    .b(strm[3]), .g(strm[4]), .r(strm[5]), .mode(cur_mode), .thr(cur_thr), .pix_out(px_out[1])
  );

  always_comb begin
    mode_ok = (mode == MODE_TH) || (mode == MODE_GRAY);
    case (state_q)
      S_IDLE:  accept = data_in_vld && mode_ok;
      S_RUN:   accept = data_in_vld;
      default: accept = 1'b0;
    endcase
    new_b      = '0;
    new_k      = '0;
    pend_d     = pend_q;
    pend_cnt_d = pend_cnt_q;
    col_d      = col_q;
    if (accept) begin
      for (int unsigned j = 0; j < 6; j++)
        if (j < 32'(npx) * 3) new_b[8*j +: 8] = (j < 3) ? px_out[0] : px_out[1];
      new_k      = 3'(npx) * 3'd3 + (3'd4 - n_pix);
      pend_cnt_d = lo;
      pend_d     = (npx == 2'd0) ? {strm[1], strm[0]} : {strm[4], strm[3]};
      col_d      = (col_q + 18'd4 >= row_bytes) ? '0 : col_q + 18'd4;
    end else if (state_q == S_FLUSH) begin
      // Incomplete pixel bytes resolve to zero.
      new_k      = 3'(pend_cnt_q);
      pend_d     = '0;
      pend_cnt_d = '0;
    end else if (state_q == S_DONE) begin
      col_d      = '0;
      pend_d     = '0;
      pend_cnt_d = '0;
    end
  end

  // Staged bytes above the count are kept at zero, so a partial final word is zero-padded.
  always_comb begin
    cmb       = {48'b0, stg_q} | (144'(new_b) << (8 * stg_cnt_q));
    cmb_cnt   = 5'(stg_cnt_q) + 5'(new_k);
    emit      = (cmb_cnt >= 5'd4) || ((state_q == S_FLUSH) && (cmb_cnt != '0));
    rem       = emit ? (cmb >> 32) : cmb;
    rem_cnt   = emit ? ((cmb_cnt >= 5'd4) ? cmb_cnt - 5'd4 : '0) : cmb_cnt;
    ovf       = rem_cnt > 5'(STG_BYTES);
    stg_d     = rem[95:0];
    stg_cnt_d = ovf ? 4'(STG_BYTES) : 4'(rem_cnt);
  end

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = eof ? S_FLUSH : S_RUN;
      S_RUN:   if (eof) state_d = S_FLUSH;
      S_FLUSH: begin
        err_set = data_in_vld;
        if (rem_cnt == '0) state_d = S_DONE;
      end
      S_DONE: begin
        err_set = data_in_vld;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      thr_q      <= '0;
      width_q    <= '0;
      col_q      <= '0;
      pend_q     <= '0;
      pend_cnt_q <= '0;
      stg_q      <= '0;
      stg_cnt_q  <= '0;
      data_out   <= '0;
      vld_out    <= 1'b0;
      proc_done  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
      stg_q      <= stg_d;
      stg_cnt_q  <= stg_cnt_d;
      if ((state_q == S_IDLE) && accept) begin
        mode_q  <= mode;
        thr_q   <= data_proc;
        width_q <= width_px;
      end
      vld_out <= emit;
      if (emit) data_out <= cmb[DATA_BUS_SIZE-1:0];
      proc_done <= (state_q == S_DONE);
      err       <= err | err_set | ovf;
    end
  end

endmodule
